sa_read_arbiter: RTL and testbench

SA_READ_ARBITER -- requirements
Module: sa_read_arbiter

---
 rtl/sa_read_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_sa_read_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_read_arbiter.sv
// sa_read_arbiter
//   Shares one AXI read slave between MST_AMT master dispatchers.
//   AR channel: two-state FSM (IDLE/GRANT) with a round-robin grant that is
//   held until the slave accepts the address. Each accepted AR pushes its
//   master index into an order FIFO.
//   R channel: beats are steered to the master at the FIFO head; the head
//   is popped on the RLAST handshake.
//
// Ports
//   ACLK_i, ARESET_i       clock, asynchronous active-high reset
//   m_AR*_i / m_ARREADY_o  per-master AR channel, master k in slice k
//   m_RREADY_i             per-master R ready
//   m_R*_o / m_RVALID_o    R payload replicated per slice, per-master valid
//   s_AR*_o / s_ARREADY_i  AR channel to the slave
//   s_R*_i / s_RREADY_o    R channel from the slave
module sa_read_arbiter #(
  parameter int MST_AMT           = 2,
  parameter int OUTSTANDING_AMT   = 8,
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int MST_ID_W          = $clog2(MST_AMT)
) (
  input  logic                                  ACLK_i,
  input  logic                                  ARESET_i,
  input  logic [TRANS_MST_ID_W*MST_AMT-1:0]     m_ARID_i,
  input  logic [ADDR_WIDTH*MST_AMT-1:0]         m_ARADDR_i,
  input  logic [TRANS_BURST_W*MST_AMT-1:0]      m_ARBURST_i,
  input  logic [TRANS_DATA_LEN_W*MST_AMT-1:0]   m_ARLEN_i,
  input  logic [TRANS_DATA_SIZE_W*MST_AMT-1:0]  m_ARSIZE_i,
  input  logic [MST_AMT-1:0]                    m_ARVALID_i,
  output logic [MST_AMT-1:0]                    m_ARREADY_o,
  input  logic [MST_AMT-1:0]                    m_RREADY_i,
  output logic [TRANS_MST_ID_W*MST_AMT-1:0]     m_RID_o,
  output logic [DATA_WIDTH*MST_AMT-1:0]         m_RDATA_o,
  output logic [MST_AMT-1:0]                    m_RLAST_o,
  output logic [MST_AMT-1:0]                    m_RVALID_o,
  output logic [TRANS_MST_ID_W-1:0]             s_ARID_o,
  output logic [ADDR_WIDTH-1:0]                 s_ARADDR_o,
  output logic [TRANS_BURST_W-1:0]              s_ARBURST_o,
  output logic [TRANS_DATA_LEN_W-1:0]           s_ARLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]          s_ARSIZE_o,
  output logic                                  s_ARVALID_o,
  input  logic                                  s_ARREADY_i,
  input  logic [TRANS_MST_ID_W-1:0]             s_RID_i,
  input  logic [DATA_WIDTH-1:0]                 s_RDATA_i,
  input  logic                                  s_RLAST_i,
  input  logic                                  s_RVALID_i,
  output logic                                  s_RREADY_o
);

  localparam int PTR_W = (OUTSTANDING_AMT > 1) ? $clog2(OUTSTANDING_AMT) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING_AMT + 1);

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t               r_state;
  logic [MST_ID_W-1:0]  r_grant;
  logic [MST_ID_W-1:0]  r_last_grant;
  logic [MST_ID_W-1:0]  r_order [OUTSTANDING_AMT];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;

  logic [MST_ID_W-1:0]  w_rr_pick;
  logic                 w_rr_found;
  logic [MST_ID_W-1:0]  w_head;
  logic                 w_empty;
  logic                 w_not_full;
  logic                 w_ar_hs;
  logic                 w_r_pop;

  assign w_head     = r_order[r_rd_ptr];
  assign w_empty    = (r_count == '0);
  assign w_not_full = (r_count < CNT_W'(OUTSTANDING_AMT));
  assign w_ar_hs    = (r_state == ST_GRANT) && s_ARREADY_i;
  assign w_r_pop    = !w_empty && s_RVALID_i && m_RREADY_i[w_head] && s_RLAST_i;

  // Round robin: the lowest requester above last_grant wins; if none, the
  // lowest requester at or below it. Descending loops let the last hit
  // (lowest index) win, and the second loop overrides the wrap-around pass.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_pick  = r_last_grant;
    for (int unsigned k = MST_AMT; k > 0; k--) begin
      if (m_ARVALID_i[k-1] && (MST_ID_W'(k-1) <= r_last_grant)) begin
        w_rr_pick  = MST_ID_W'(k-1);
        w_rr_found = 1'b1;
      end
    end
    for (int unsigned k = MST_AMT; k > 0; k--) begin
      if (m_ARVALID_i[k-1] && (MST_ID_W'(k-1) > r_last_grant)) begin
        w_rr_pick  = MST_ID_W'(k-1);
        w_rr_found = 1'b1;
      end
    end
  end

  // AR FSM: grant is captured in IDLE and held unchanged through GRANT.
  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= MST_ID_W'(MST_AMT - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rr_found && w_not_full) begin
            r_grant <= w_rr_pick;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (s_ARREADY_i) begin
            r_last_grant <= r_grant;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Order FIFO pointers and occupancy.
  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_ar_hs) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_r_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(OUTSTANDING_AMT - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_ar_hs, w_r_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge ACLK_i) begin
    if (w_ar_hs) begin
      r_order[r_wr_ptr] <= r_grant;
    end
  end

  // AR payload mux and per-master ready.
  always_comb begin
    s_ARID_o    = '0;
    s_ARADDR_o  = '0;
    s_ARBURST_o = '0;
    s_ARLEN_o   = '0;
    s_ARSIZE_o  = '0;
    for (int unsigned k = 0; k < MST_AMT; k++) begin
      if (MST_ID_W'(k) == r_grant) begin
        s_ARID_o    = m_ARID_i[k*TRANS_MST_ID_W +: TRANS_MST_ID_W];
        s_ARADDR_o  = m_ARADDR_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        s_ARBURST_o = m_ARBURST_i[k*TRANS_BURST_W +: TRANS_BURST_W];
        s_ARLEN_o   = m_ARLEN_i[k*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
        s_ARSIZE_o  = m_ARSIZE_i[k*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
      end
    end
  end

  assign s_ARVALID_o = (r_state == ST_GRANT);

  always_comb begin
    m_ARREADY_o = '0;
    if (r_state == ST_GRANT) begin
      m_ARREADY_o[r_grant] = s_ARREADY_i;
    end
  end

  // R steering to the FIFO head.
  always_comb begin
    m_RVALID_o = '0;
    if (!w_empty) begin
      m_RVALID_o[w_head] = s_RVALID_i;
    end
  end

  assign s_RREADY_o = !w_empty && m_RREADY_i[w_head];
  assign m_RID_o    = {MST_AMT{s_RID_i}};
  assign m_RDATA_o  = {MST_AMT{s_RDATA_i}};
  assign m_RLAST_o  = {MST_AMT{s_RLAST_i}};

endmodule

// File: tb/tb_sa_read_arbiter.sv
module tb_sa_read_arbiter;

  localparam int MST = 2;
  localparam int OUT = 8;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int IDW = 5;
  localparam int BW  = 2;
  localparam int LW  = 3;
  localparam int SW  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [IDW*MST-1:0] m_arid;
  logic [AW*MST-1:0]  m_araddr;
  logic [BW*MST-1:0]  m_arburst;
  logic [LW*MST-1:0]  m_arlen;
  logic [SW*MST-1:0]  m_arsize;
  logic [MST-1:0]     m_arvalid, m_arready, m_rready, m_rlast, m_rvalid;
  logic [IDW*MST-1:0] m_rid;
  logic [DW*MST-1:0]  m_rdata;
  logic [IDW-1:0]     s_arid, s_rid;
  logic [AW-1:0]      s_araddr;
  logic [BW-1:0]      s_arburst;
  logic [LW-1:0]      s_arlen;
  logic [SW-1:0]      s_arsize;
  logic               s_arvalid, s_arready;
  logic [DW-1:0]      s_rdata;
  logic               s_rlast, s_rvalid, s_rready;

  always #5 clk = ~clk;

  sa_read_arbiter #(
    .MST_AMT(MST), .OUTSTANDING_AMT(OUT), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .TRANS_MST_ID_W(IDW), .TRANS_BURST_W(BW), .TRANS_DATA_LEN_W(LW),
    .TRANS_DATA_SIZE_W(SW)
  ) dut (
    .ACLK_i(clk), .ARESET_i(rst),
    .m_ARID_i(m_arid), .m_ARADDR_i(m_araddr), .m_ARBURST_i(m_arburst),
    .m_ARLEN_i(m_arlen), .m_ARSIZE_i(m_arsize), .m_ARVALID_i(m_arvalid),
    .m_ARREADY_o(m_arready), .m_RREADY_i(m_rready),
    .m_RID_o(m_rid), .m_RDATA_o(m_rdata), .m_RLAST_o(m_rlast), .m_RVALID_o(m_rvalid),
    .s_ARID_o(s_arid), .s_ARADDR_o(s_araddr), .s_ARBURST_o(s_arburst),
    .s_ARLEN_o(s_arlen), .s_ARSIZE_o(s_arsize), .s_ARVALID_o(s_arvalid),
    .s_ARREADY_i(s_arready),
    .s_RID_i(s_rid), .s_RDATA_i(s_rdata), .s_RLAST_i(s_rlast), .s_RVALID_i(s_rvalid),
    .s_RREADY_o(s_rready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a pending grant (-1 when none) and a queue holding
  // the master of every accepted AR whose last beat is still owed.
  int mdl_grant = -1;
  int mdl_last  = MST - 1;
  int mdl_q[$];
  int mdl_n;
  bit mdl_push, mdl_pop, mdl_found;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_grant = -1;
      mdl_last  = MST - 1;
      mdl_q.delete();
    end else begin
      mdl_n    = mdl_q.size();
      mdl_push = (mdl_grant >= 0) && s_arready;
      mdl_pop  = (mdl_n > 0) && s_rvalid && m_rready[mdl_q[0]] && s_rlast;
      if (mdl_pop) void'(mdl_q.pop_front());
      if (mdl_push) begin
        mdl_q.push_back(mdl_grant);
        mdl_last  = mdl_grant;
        mdl_grant = -1;
      end else if (mdl_grant < 0 && mdl_n < OUT) begin
        mdl_found = 1'b0;
        for (int i = 1; i <= MST; i++) begin
          if (!mdl_found && m_arvalid[(mdl_last + i) % MST]) begin
            mdl_grant = (mdl_last + i) % MST;
            mdl_found = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : cmp
    logic [MST-1:0] e_ar, e_rv;
    logic           e_rr;
    e_ar = '0;
    e_rv = '0;
    e_rr = 1'b0;
    chk("s_ARVALID", 64'(s_arvalid), 64'(mdl_grant >= 0));
    if (mdl_grant >= 0) begin
      e_ar[mdl_grant] = s_arready;
      chk("s_ARADDR", 64'(s_araddr), 64'(m_araddr[mdl_grant*AW +: AW]));
      chk("s_ARID",   64'(s_arid),   64'(m_arid[mdl_grant*IDW +: IDW]));
      chk("s_ARLEN",  64'(s_arlen),  64'(m_arlen[mdl_grant*LW +: LW]));
    end
    chk("m_ARREADY", 64'(m_arready), 64'(e_ar));
    if (mdl_q.size() > 0) begin
      e_rv[mdl_q[0]] = s_rvalid;
      e_rr = m_rready[mdl_q[0]];
    end
    chk("m_RVALID", 64'(m_rvalid), 64'(e_rv));
    chk("s_RREADY", 64'(s_rready), 64'(e_rr));
    chk("m_RDATA",  64'(m_rdata),  64'({MST{s_rdata}}));
    chk("m_RLAST",  64'(m_rlast),  64'({MST{s_rlast}}));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_arvalid(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (s_arvalid) got = 1'b1;
    end
    chk(name, 64'(got), 64'd1);
  endtask

  logic [AW-1:0]  cap_addr [4];
  logic [MST-1:0] cap_rdy  [4];
  int             ncap;

  initial begin
    m_arid    = {5'h11, 5'h10};
    m_araddr  = {32'hB000_0001, 32'hA000_0000};
    m_arburst = {2'b01, 2'b01};
    m_arlen   = {3'd3, 3'd0};
    m_arsize  = {3'd2, 3'd2};
    m_arvalid = 2'b11;
    m_rready  = 2'b11;
    s_arready = 1'b1;
    s_rid     = 5'h07;
    s_rdata   = 32'h1234_5678;
    s_rlast   = 1'b1;
    s_rvalid  = 1'b1;

    // Outputs stay quiet while reset is held, even with traffic applied.
    @(negedge clk);
    chk("rst_arvalid", 64'(s_arvalid), 64'd0);
    chk("rst_rready",  64'(s_rready),  64'd0);
    chk("rst_arready", 64'(m_arready), 64'd0);
    chk("rst_rvalid",  64'(m_rvalid),  64'd0);

    // Both masters requesting: grants alternate 0,1,0,1.
    step();
    rst      = 1'b0;
    s_rvalid = 1'b0;
    ncap = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (s_arvalid && ncap < 4) begin
        cap_addr[ncap] = s_araddr;
        cap_rdy[ncap]  = m_arready;
        ncap++;
      end
    end
    #1 m_arvalid = 2'b00;
    chk("rr_count", 64'(ncap), 64'd4);
    chk("rr_addr0", 64'(cap_addr[0]), 64'h0000_0000_A000_0000);
    chk("rr_addr1", 64'(cap_addr[1]), 64'h0000_0000_B000_0001);
    chk("rr_addr2", 64'(cap_addr[2]), 64'h0000_0000_A000_0000);
    chk("rr_addr3", 64'(cap_addr[3]), 64'h0000_0000_B000_0001);
    chk("rr_rdy0",  64'(cap_rdy[0]), 64'd1);
    chk("rr_rdy1",  64'(cap_rdy[1]), 64'd2);
    chk("rr_rdy2",  64'(cap_rdy[2]), 64'd1);
    chk("rr_rdy3",  64'(cap_rdy[3]), 64'd2);

    // Drain in order: heads 0,1,0,1, then empty.
    step();
    s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = 2'b11; s_rdata = 32'hDEAD_0000;
    @(negedge clk); chk("drain_h0", 64'(m_rvalid), 64'd1);
    step();
    @(negedge clk); chk("drain_h1", 64'(m_rvalid), 64'd2);
    repeat (3) step();
    @(negedge clk);
    chk("empty_rvalid", 64'(m_rvalid), 64'd0);
    chk("empty_rready", 64'(s_rready), 64'd0);
    #1 s_rvalid = 1'b0;

    // Master 1 burst of 4 beats: only beat 4 pops.
    step();
    m_arvalid = 2'b10;
    wait_arvalid("m1_grant");
    chk("m1_addr", 64'(s_araddr), 64'h0000_0000_B000_0001);
    chk("m1_len",  64'(s_arlen),  64'd3);
    #1 m_arvalid = 2'b00;
    step();
    s_rvalid = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      s_rlast = (b == 4);
      s_rdata = 32'(b);
      @(negedge clk);
      chk("burst_rvalid", 64'(m_rvalid), 64'd2);
      step();
    end
    @(negedge clk); chk("burst_popped", 64'(m_rvalid), 64'd0);
    #1 s_rvalid = 1'b0;

    // Master stalls R: no ready to the slave, valid held, no pop.
    step();
    m_arvalid = 2'b01;
    wait_arvalid("m0_grant");
    #1 m_arvalid = 2'b00;
    step();
    s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_rready", 64'(s_rready), 64'd0);
      chk("stall_rvalid", 64'(m_rvalid), 64'd1);
      step();
    end
    m_rready = 2'b01;
    @(negedge clk); chk("unstall_rready", 64'(s_rready), 64'd1);
    step();
    @(negedge clk); chk("unstall_pop", 64'(m_rvalid), 64'd0);
    #1 s_rvalid = 1'b0; m_rready = 2'b11;

    // Fill to OUT outstanding; the next request must wait for a pop.
    step();
    m_arvalid = 2'b01;
    repeat (20) step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("full_no_grant", 64'(s_arvalid), 64'd0);
    end
    step();
    s_rvalid = 1'b1; s_rlast = 1'b1;
    @(negedge clk); chk("full_pre_pop", 64'(s_arvalid), 64'd0);
    step();
    s_rvalid = 1'b0;
    @(negedge clk); chk("full_pop_cycle", 64'(s_arvalid), 64'd0);
    step();
    @(negedge clk); chk("full_resume", 64'(s_arvalid), 64'd1);
    #1 m_arvalid = 2'b00;
    step();
    s_rvalid = 1'b1;
    repeat (10) step();
    s_rvalid = 1'b0;

    // Occupancy 3, then push and pop in the same cycle.
    m_arvalid = 2'b11;
    repeat (6) step();
    m_arvalid = 2'b01; s_arready = 1'b0;
    step();
    s_arready = 1'b1; s_rvalid = 1'b1; s_rlast = 1'b1; m_rready = 2'b11;
    @(negedge clk);
    chk("simul_grant", 64'(s_arvalid), 64'd1);
    chk("simul_head1", 64'(m_rvalid), 64'd2);
    step();
    m_arvalid = 2'b00; m_rready = 2'b00;
    @(negedge clk); chk("simul_head0", 64'(m_rvalid), 64'd1);
    step();
    m_rready = 2'b11;
    @(negedge clk); chk("simul_q0", 64'(m_rvalid), 64'd1);
    step();
    @(negedge clk); chk("simul_q1", 64'(m_rvalid), 64'd2);
    step();
    @(negedge clk); chk("simul_q2", 64'(m_rvalid), 64'd1);
    step();
    @(negedge clk); chk("simul_empty", 64'(m_rvalid), 64'd0);
    #1 s_rvalid = 1'b0;

    // Reset in the middle of a held grant with one AR outstanding.
    step();
    m_arvalid = 2'b01;
    wait_arvalid("pre_rst_m0");
    #1 m_arvalid = 2'b10; s_arready = 1'b0;
    wait_arvalid("pre_rst_m1");
    #1 rst = 1'b1;
    #1 chk("rst_mid_arvalid", 64'(s_arvalid), 64'd0);
    chk("rst_mid_arready", 64'(m_arready), 64'd0);
    step();
    rst = 1'b0; m_arvalid = 2'b11; s_arready = 1'b1;
    s_rvalid = 1'b1; s_rlast = 1'b0; m_rready = 2'b11;
    @(negedge clk); chk("post_rst_empty", 64'(s_rready), 64'd0);
    wait_arvalid("post_rst_grant");
    chk("post_rst_m0", 64'(s_araddr), 64'h0000_0000_A000_0000);
    #1 m_arvalid = 2'b00;
    step();
    s_rvalid = 1'b0;
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
